// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution unit with iterative one-bit-per-cycle shifts
module alu_exec_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         carry,
    output logic         illegal,
    output logic         busy
);
    localparam int CW = $clog2(W + 1);
    localparam logic [W:0] W_EXT = (W + 1)'(W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LSH = 3'b001;
    localparam logic [2:0] OP_RSH = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t         r_state;
    logic [W-1:0]   r_result;
    logic           r_zero;
    logic           r_carry;
    logic           r_illegal;
    logic           r_out_valid;
    logic [CW-1:0]  r_cnt;
    logic           r_left;

    logic [CW-1:0]  w_n;
    logic           w_is_shift;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_res;
    logic           w_carry;
    logic           w_ill;
    logic [W-1:0]   w_shift_next;
    logic           w_shift_out;

    // Shift amounts of W or more saturate so the SHIFT phase is bounded.
    always_comb begin
        w_n        = ({1'b0, b} >= W_EXT) ? CW'(W) : b[CW-1:0];
        w_is_shift = (op == OP_LSH) || (op == OP_RSH);
        w_sum      = {1'b0, a} + {1'b0, b};
        w_res      = '0;
        w_carry    = 1'b0;
        w_ill      = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[W-1:0];
                w_carry = w_sum[W];
            end
            OP_SUB: begin
                w_res   = a - b;
                w_carry = (a >= b);
            end
            OP_LSH, OP_RSH: w_res = a;
            OP_XOR: w_res = a ^ b;
            OP_AND: w_res = a & b;
            OP_CLR: w_res = '0;
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_shift_next = r_left ? {r_result[W-2:0], 1'b0} : {1'b0, r_result[W-1:1]};
        w_shift_out  = r_left ? r_result[W-1] : r_result[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_left      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_shift && (w_n != '0)) begin
                            r_state   <= S_SHIFT;
                            r_cnt     <= w_n;
                            r_result  <= a;
                            r_left    <= (op == OP_LSH);
                            r_carry   <= 1'b0;
                            r_illegal <= 1'b0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_carry     <= w_carry;
                            r_illegal   <= w_ill;
                        end
                    end
                end
                S_SHIFT: begin
                    r_result <= w_shift_next;
                    r_carry  <= w_shift_out;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_zero      <= (w_shift_next == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         illegal;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: expected outputs and latency from the arithmetic rules directly.
    function automatic void model(input int o, input int ia, input int ib,
                                  output int r, output int c, output int z,
                                  output int il, output int lat);
        int mask;
        int n;
        mask = (1 << W) - 1;
        n  = (ib >= W) ? W : ib;
        r  = 0; c = 0; il = 0; lat = 1;
        case (o)
            0: begin r = (ia + ib) & mask; c = (ia + ib) >> W; end
            1: begin
                r = (ia << n) & mask;
                c = (n == 0) ? 0 : ((ia >> (W - n)) & 1);
                lat = 1 + n;
            end
            2: begin
                r = ia >> n;
                c = (n == 0) ? 0 : ((ia >> (n - 1)) & 1);
                lat = 1 + n;
            end
            3: r = ia ^ ib;
            4: r = ia & ib;
            5: begin r = (ia - ib) & mask; c = (ia >= ib) ? 1 : 0; end
            6: r = 0;
            default: il = 1;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    // Called #1 after a posedge with the unit idle; returns cycles from accept to out_valid.
    task automatic issue(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         output int lat, output bit busy_ok);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, result, zero, carry, illegal, busy, in_ready} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got ov=%b r=%h z=%b c=%b il=%b busy=%b rdy=%b",
                     out_valid, result, zero, carry, illegal, busy, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        int lat; bit bo;
        issue(3'b000, 8'hF0, 8'h20, lat, bo);
        checks++;
        if ({lat == 1, result, carry, zero, illegal} !== {1'b1, 8'h10, 3'b100}) begin
            errors++;
            $display("FAIL add lat=%0d r=%h c=%b z=%b il=%b exp lat=1 r=10 c=1 z=0 il=0", lat, result, carry, zero, illegal);
        end
        drain();
        issue(3'b101, 8'h05, 8'h05, lat, bo);
        checks++;
        if ({result, zero, carry} !== {8'h00, 2'b11}) begin
            errors++;
            $display("FAIL sub_eq r=%h z=%b c=%b exp r=00 z=1 c=1", result, zero, carry);
        end
        drain();
        issue(3'b101, 8'h03, 8'h05, lat, bo);
        checks++;
        if ({result, carry, zero} !== {8'hFE, 2'b00}) begin
            errors++;
            $display("FAIL sub_borrow r=%h c=%b z=%b exp r=fe c=0 z=0", result, carry, zero);
        end
        drain();
    endtask

    task automatic test_shift();
        int lat; bit bo;
        issue(3'b001, 8'h81, 8'd3, lat, bo);
        checks++;
        if (lat != 4 || result !== 8'h08 || carry !== 1'b0 || !bo) begin
            errors++;
            $display("FAIL lsh3 lat=%0d r=%h c=%b busy_ok=%b exp lat=4 r=08 c=0 busy_ok=1", lat, result, carry, bo);
        end
        drain();
        issue(3'b010, 8'h81, 8'd1, lat, bo);
        checks++;
        if (lat != 2 || result !== 8'h40 || carry !== 1'b1) begin
            errors++;
            $display("FAIL rsh1 lat=%0d r=%h c=%b exp lat=2 r=40 c=1", lat, result, carry);
        end
        drain();
        issue(3'b010, 8'h81, 8'd200, lat, bo);
        checks++;
        if (lat != 9 || result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
            errors++;
            $display("FAIL rsh_sat lat=%0d r=%h z=%b c=%b exp lat=9 r=00 z=1 c=1", lat, result, zero, carry);
        end
        drain();
        issue(3'b001, 8'h5A, 8'd0, lat, bo);
        checks++;
        if (lat != 1 || result !== 8'h5A || carry !== 1'b0) begin
            errors++;
            $display("FAIL lsh0 lat=%0d r=%h c=%b exp lat=1 r=5a c=0", lat, result, carry);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat; bit bo; bit stable;
        issue(3'b000, 8'h33, 8'h44, lat, bo);
        stable = 1'b1;
        op = 3'b101; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h77 ||
                carry !== 1'b0 || zero !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL hold_stable got ov=%b rdy=%b r=%h exp ov=1 rdy=0 r=77", out_valid, in_ready, result);
        end
        op = 3'b011; a = 8'hA5; b = 8'h0F;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle rdy=%b ov=%b exp rdy=1 ov=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hAA) begin
            errors++;
            $display("FAIL next_accept ov=%b r=%h exp ov=1 r=aa", out_valid, result);
        end
        drain();
    endtask

    task automatic test_reset_mid_shift();
        int lat; bit bo; bit quiet;
        op = 3'b001; a = 8'hFF; b = 8'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ov=%b r=%h rdy=%b busy=%b exp ov=0 r=00 rdy=1 busy=0", out_valid, result, in_ready, busy);
        end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL stale_output out_valid rose after reset abort exp 0");
        end
        issue(3'b111, 8'h12, 8'h34, lat, bo);
        checks++;
        if ({illegal, result, zero, carry} !== {1'b1, 8'h00, 2'b10} || lat != 1) begin
            errors++;
            $display("FAIL illegal il=%b r=%h z=%b c=%b lat=%0d exp il=1 r=00 z=1 c=0 lat=1", illegal, result, zero, carry, lat);
        end
        drain();
    endtask

    task automatic test_random();
        int lat; bit bo;
        int er, ec, ez, eil, elat;
        int ro, ra, rb;
        for (int i = 0; i < 60; i++) begin
            ro = $urandom_range(0, 7);
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 10);
            model(ro, ra, rb, er, ec, ez, eil, elat);
            issue(3'(ro), 8'(ra), 8'(rb), lat, bo);
            checks++;
            if (result !== 8'(er) || carry !== 1'(ec) || zero !== 1'(ez) ||
                illegal !== 1'(eil) || lat != elat) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h got r=%h c=%b z=%b il=%b lat=%0d exp r=%h c=%0d z=%0d il=%0d lat=%0d",
                         ro, ra, rb, result, carry, zero, illegal, lat, er, ec, ez, eil, elat);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
